// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor: counter encodings, predictor modes
// and the word-PC type used on every address port.
package branch_predictor_pkg;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    localparam int MODE_STATIC_NT = 0;
    localparam int MODE_BIMODAL   = 1;
    localparam int MODE_BTB_HIT   = 2;

    typedef logic [31:2] word_pc_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating up/down counter step, used once on the table update path.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_next
);

    // Move one step toward the observed outcome, holding at either end.
    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != CNT_ST) cnt_next = cnt + 2'd1;
        end else begin
            if (cnt != CNT_SNT) cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit counters. Lookup is combinational;
// updates from the resolve stage land on the next rising edge, so a lookup in
// the same cycle as an update to its index still sees the old entry.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int MODE    = 1
)(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lkp_valid_i,
    input  word_pc_t    lkp_pc_i,
    output logic        pred_taken_o,
    output word_pc_t    pred_target_o,
    input  logic        upd_valid_i,
    input  word_pc_t    upd_pc_i,
    input  logic        upd_taken_i,
    input  word_pc_t    upd_target_i,
    input  logic        upd_pred_taken_i,
    input  word_pc_t    upd_pred_target_i,
    input  logic        flush_i,
    output logic        mispredict_o,
    output logic [31:0] lkp_count_o,
    output logic [31:0] mispred_count_o
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic             tbl_valid  [ENTRIES];
    logic [TAG_W-1:0] tbl_tag    [ENTRIES];
    logic [1:0]       tbl_cnt    [ENTRIES];
    word_pc_t         tbl_target [ENTRIES];

    logic [IDX_W-1:0] lkp_idx;
    logic [TAG_W-1:0] lkp_tag;
    logic             lkp_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [1:0]       upd_cnt_next;
    logic             tbl_we;
    logic             unused_upd_pc;

    assign lkp_idx = lkp_pc_i[IDX_W+1:2];
    assign lkp_tag = lkp_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

    // PC bits above the tag do not participate in the update path.
    assign unused_upd_pc = ^upd_pc_i;

    assign lkp_hit = tbl_valid[lkp_idx] && (tbl_tag[lkp_idx] == lkp_tag);
    assign upd_hit = tbl_valid[upd_idx] && (tbl_tag[upd_idx] == upd_tag);

    // Prediction: valid bits are cleared by reset, so a reset forces not-taken.
    always_comb begin
        pred_taken_o = 1'b0;
        if (MODE == MODE_BIMODAL)     pred_taken_o = lkp_hit && tbl_cnt[lkp_idx][1];
        else if (MODE == MODE_BTB_HIT) pred_taken_o = lkp_hit;
        pred_target_o = pred_taken_o ? tbl_target[lkp_idx] : lkp_pc_i + 30'd1;
    end

    assign mispredict_o = upd_valid_i &&
                          ((upd_taken_i != upd_pred_taken_i) ||
                           (upd_taken_i && (upd_target_i != upd_pred_target_i)));

    sat_counter2 u_sat_counter2 (
        .cnt      (tbl_cnt[upd_idx]),
        .taken    (upd_taken_i),
        .cnt_next (upd_cnt_next)
    );

    // Static mode never touches the table; otherwise hits train and taken misses allocate.
    assign tbl_we = upd_valid_i && (MODE != MODE_STATIC_NT) && (upd_hit || upd_taken_i);

    // Table state: flush beats a simultaneous update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i]  <= 1'b0;
                tbl_tag[i]    <= '0;
                tbl_cnt[i]    <= CNT_WNT;
                tbl_target[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i] <= 1'b0;
            end
        end else if (tbl_we) begin
            if (upd_hit) begin
                tbl_cnt[upd_idx] <= upd_cnt_next;
                if (upd_taken_i) tbl_target[upd_idx] <= upd_target_i;
            end else begin
                tbl_valid[upd_idx]  <= 1'b1;
                tbl_tag[upd_idx]    <= upd_tag;
                tbl_cnt[upd_idx]    <= CNT_WT;
                tbl_target[upd_idx] <= upd_target_i;
            end
        end
    end

    // Saturating statistics counters; flush leaves them alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lkp_count_o     <= '0;
            mispred_count_o <= '0;
        end else begin
            if (lkp_valid_i && (lkp_count_o != 32'hFFFF_FFFF))
                lkp_count_o <= lkp_count_o + 32'd1;
            if (mispredict_o && (mispred_count_o != 32'hFFFF_FFFF))
                mispred_count_o <= mispred_count_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a bimodal instance and a static instance share the
// same stimulus; expectations come from a small reference table model.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        lkp_valid_i = 1'b0;
    logic [29:0] lkp_pc_i = '0;
    logic        upd_valid_i = 1'b0;
    logic [29:0] upd_pc_i = '0;
    logic        upd_taken_i = 1'b0;
    logic [29:0] upd_target_i = '0;
    logic        upd_pred_taken_i = 1'b0;
    logic [29:0] upd_pred_target_i = '0;
    logic        flush_i = 1'b0;

    logic        pred_taken_1, pred_taken_0;
    logic [29:0] pred_target_1, pred_target_0;
    logic        mispredict_1, mispredict_0;
    logic [31:0] lkp_count_1, lkp_count_0;
    logic [31:0] mispred_count_1, mispred_count_0;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    branch_predictor #(.ENTRIES(16), .TAG_W(8), .MODE(MODE_BIMODAL)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lkp_valid_i(lkp_valid_i), .lkp_pc_i(lkp_pc_i),
        .pred_taken_o(pred_taken_1), .pred_target_o(pred_target_1),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
        .upd_target_i(upd_target_i), .upd_pred_taken_i(upd_pred_taken_i),
        .upd_pred_target_i(upd_pred_target_i), .flush_i(flush_i),
        .mispredict_o(mispredict_1), .lkp_count_o(lkp_count_1),
        .mispred_count_o(mispred_count_1)
    );

    branch_predictor #(.ENTRIES(16), .TAG_W(8), .MODE(MODE_STATIC_NT)) u_dut_static (
        .clk_i(clk_i), .rst_i(rst_i),
        .lkp_valid_i(lkp_valid_i), .lkp_pc_i(lkp_pc_i),
        .pred_taken_o(pred_taken_0), .pred_target_o(pred_target_0),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
        .upd_target_i(upd_target_i), .upd_pred_taken_i(upd_pred_taken_i),
        .upd_pred_target_i(upd_pred_target_i), .flush_i(flush_i),
        .mispredict_o(mispredict_0), .lkp_count_o(lkp_count_0),
        .mispred_count_o(mispred_count_0)
    );

    // reference model of the bimodal table and the statistics counters
    logic        m_valid [16];
    logic [7:0]  m_tag   [16];
    logic [1:0]  m_cnt   [16];
    logic [29:0] m_tgt   [16];
    logic [31:0] m_lkp;
    logic [31:0] m_mp;

    typedef struct {
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    function automatic string sel_name(input int sel);
        case (sel)
            0: return "m1_pred_taken";
            1: return "m1_pred_target";
            2: return "m1_mispredict";
            3: return "m1_lkp_count";
            4: return "m1_mispred_count";
            5: return "m0_pred_taken";
            6: return "m0_pred_target";
            7: return "m0_mispredict";
            8: return "m0_mispred_count";
            default: return "m0_lkp_count";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0: return {31'd0, pred_taken_1};
            1: return {2'd0, pred_target_1};
            2: return {31'd0, mispredict_1};
            3: return lkp_count_1;
            4: return mispred_count_1;
            5: return {31'd0, pred_taken_0};
            6: return {2'd0, pred_target_0};
            7: return {31'd0, mispredict_0};
            8: return mispred_count_0;
            default: return lkp_count_0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_cnt[i]   = 2'b01;
            m_tgt[i]   = '0;
        end
        m_lkp = '0;
        m_mp  = '0;
    endtask

    task automatic push(input int sel, input logic [31:0] exp);
        exp_t e;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // One clock: drive, predict, compare at negedge, then advance the model.
    task automatic step(input bit lv, input logic [29:0] lpc,
                        input bit uv, input logic [29:0] upc, input bit ut,
                        input logic [29:0] utgt, input bit upt,
                        input logic [29:0] uptgt, input bit fl);
        logic [3:0]  li, ui;
        logic        hit, uh, et, emp;
        logic [29:0] etg;
        exp_t        e;
        lkp_valid_i = lv; lkp_pc_i = lpc;
        upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut; upd_target_i = utgt;
        upd_pred_taken_i = upt; upd_pred_target_i = uptgt; flush_i = fl;

        li  = lpc[3:0];
        hit = m_valid[li] && (m_tag[li] == lpc[11:4]);
        et  = hit && m_cnt[li][1];
        etg = et ? m_tgt[li] : lpc + 30'd1;
        emp = uv && ((ut != upt) || (ut && (utgt != uptgt)));
        if (lv) begin
            push(0, {31'd0, et});
            push(1, {2'd0, etg});
            push(5, 32'd0);
            push(6, {2'd0, lpc + 30'd1});
        end
        push(2, {31'd0, emp});
        push(7, {31'd0, emp});
        push(3, m_lkp);
        push(9, m_lkp);
        push(4, m_mp);
        push(8, m_mp);

        @(negedge clk_i);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(sel_name(e.sel), actual(e.sel), e.exp);
        end

        @(posedge clk_i);
        if (lv && m_lkp != 32'hFFFF_FFFF) m_lkp++;
        if (emp && m_mp != 32'hFFFF_FFFF) m_mp++;
        ui = upc[3:0];
        uh = m_valid[ui] && (m_tag[ui] == upc[11:4]);
        if (fl) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end else if (uv) begin
            if (uh) begin
                if (ut) begin
                    if (m_cnt[ui] != 2'b11) m_cnt[ui] = m_cnt[ui] + 2'd1;
                    m_tgt[ui] = utgt;
                end else if (m_cnt[ui] != 2'b00) begin
                    m_cnt[ui] = m_cnt[ui] - 2'd1;
                end
            end else if (ut) begin
                m_valid[ui] = 1'b1;
                m_tag[ui]   = upc[11:4];
                m_cnt[ui]   = 2'b10;
                m_tgt[ui]   = utgt;
            end
        end
        #1;
    endtask

    logic [29:0] pc_pool [8];

    initial begin
        pc_pool[0] = 30'h40;  pc_pool[1] = 30'h440; pc_pool[2] = 30'h80;
        pc_pool[3] = 30'h10;  pc_pool[4] = 30'h3;   pc_pool[5] = 30'h13;
        pc_pool[6] = 30'h1c3; pc_pool[7] = 30'h3fff_ffff;
        model_reset();

        // reset state
        lkp_valid_i = 1'b1; lkp_pc_i = 30'h40;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_lkp_count", lkp_count_1, 32'd0);
        chk("rst_mispred_count", mispred_count_1, 32'd0);
        chk("rst_pred_taken", {31'd0, pred_taken_1}, 32'd0);
        chk("rst_pred_target", {2'd0, pred_target_1}, 32'h41);
        lkp_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // allocate 0x40; same-cycle lookup sees the old (empty) entry
        step(1, 30'h40, 0, 0, 0, 0, 0, 0, 0);
        step(1, 30'h40, 1, 30'h40, 1, 30'h100, 0, 30'h41, 0);
        step(1, 30'h40, 0, 0, 0, 0, 0, 0, 0);
        // train down to 00 and hold there
        step(1, 30'h40, 1, 30'h40, 0, 30'h41, 1, 30'h100, 0);
        step(1, 30'h40, 1, 30'h40, 0, 30'h41, 0, 30'h41, 0);
        step(1, 30'h40, 1, 30'h40, 0, 30'h41, 0, 30'h41, 0);
        step(1, 30'h40, 1, 30'h40, 1, 30'h100, 0, 30'h41, 0);
        step(1, 30'h40, 1, 30'h40, 1, 30'h104, 0, 30'h41, 0);
        step(1, 30'h40, 0, 0, 0, 0, 0, 0, 0);
        // conflicting tag at the same index evicts the old occupant
        step(0, 0, 1, 30'h440, 1, 30'h200, 0, 30'h441, 0);
        step(1, 30'h40, 0, 0, 0, 0, 0, 0, 0);
        step(1, 30'h440, 0, 0, 0, 0, 0, 0, 0);
        // correct direction, wrong target
        step(1, 30'h440, 1, 30'h10, 1, 30'h24, 1, 30'h20, 0);
        step(1, 30'h10, 0, 0, 0, 0, 0, 0, 0);
        // flush beats a simultaneous allocation
        step(1, 30'h10, 1, 30'h80, 1, 30'h300, 0, 30'h81, 1);
        step(1, 30'h80, 0, 0, 0, 0, 0, 0, 0);
        step(1, 30'h10, 0, 0, 0, 0, 0, 0, 0);
        // target wraps modulo 2^30
        step(1, 30'h3fff_ffff, 0, 0, 0, 0, 0, 0, 0);

        // random traffic over a small PC pool with aliasing indices
        for (int n = 0; n < 300; n++) begin
            step($urandom_range(0, 3) != 0, pc_pool[$urandom_range(0, 7)],
                 $urandom_range(0, 1) == 1, pc_pool[$urandom_range(0, 7)],
                 $urandom_range(0, 1) == 1, pc_pool[$urandom_range(0, 7)],
                 $urandom_range(0, 1) == 1, pc_pool[$urandom_range(0, 7)],
                 $urandom_range(0, 40) == 0);
        end

        // mid-run reset discards a pending update
        step(0, 0, 1, 30'h40, 1, 30'h100, 1, 30'h100, 0);
        lkp_valid_i = 1'b1; lkp_pc_i = 30'h40;
        upd_valid_i = 1'b1; upd_pc_i = 30'h80; upd_taken_i = 1'b1;
        upd_target_i = 30'h300; upd_pred_taken_i = 1'b0; upd_pred_target_i = 30'h81;
        flush_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        chk("midrst_lkp_count", lkp_count_1, 32'd0);
        chk("midrst_mispred_count", mispred_count_1, 32'd0);
        chk("midrst_m0_lkp_count", lkp_count_0, 32'd0);
        chk("midrst_pred_taken", {31'd0, pred_taken_1}, 32'd0);
        chk("midrst_pred_target", {2'd0, pred_target_1}, 32'h41);
        chk("midrst_mispredict", {31'd0, mispredict_1}, 32'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        upd_valid_i = 1'b0; lkp_valid_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;
        step(1, 30'h80, 0, 0, 0, 0, 0, 0, 0);
        step(1, 30'h40, 0, 0, 0, 0, 0, 0, 0);
        step(1, 30'h40, 1, 30'h40, 1, 30'h100, 0, 30'h41, 0);
        step(1, 30'h40, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
